// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit sitting beside the EX-stage ALU.
// Holds the architectural HI/LO registers and reports busy while a
// MULT/MULTU/DIV/DIVU is in flight. The result is computed at the start
// edge and released to HI/LO after the fixed cycle count has elapsed.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Src1,
    input  logic [31:0] Src2,
    input  logic [2:0]  mdOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Handshake: a request is accepted only on an edge where state is IDLE,
    // start=1 and mdOp is 1-4. busy is high from the next cycle for exactly
    // the op's cycle count; start seen while busy is dropped without effect.
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic          res_wr;

    logic          op_start;
    logic          op_done;

    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic [31:0]   mag1;
    logic [31:0]   mag2;
    logic [31:0]   q_u;
    logic [31:0]   r_u;
    logic [31:0]   q_mag;
    logic [31:0]   r_mag;
    logic [31:0]   q_s;
    logic [31:0]   r_s;
    logic [31:0]   new_hi;
    logic [31:0]   new_lo;
    logic          new_wr;
    logic [CW-1:0] new_cnt;

    assign op_start = (state == IDLE) && start && (mdOp >= OP_MULT) && (mdOp <= OP_DIVU);
    assign op_done  = (state == RUN) && (cnt == CW'(1));
    assign busy     = (state == RUN);

    // Result of the requested operation on the current operands; a divide by
    // zero keeps the old HI/LO by clearing the write enable.
    always_comb begin
        prod_s  = {{32{Src1[31]}}, Src1} * {{32{Src2[31]}}, Src2};
        prod_u  = {32'd0, Src1} * {32'd0, Src2};
        mag1    = Src1[31] ? (~Src1 + 32'd1) : Src1;
        mag2    = Src2[31] ? (~Src2 + 32'd1) : Src2;
        q_u     = 32'd0;
        r_u     = 32'd0;
        q_mag   = 32'd0;
        r_mag   = 32'd0;
        if (Src2 != 32'd0) begin
            q_u   = Src1 / Src2;
            r_u   = Src1 % Src2;
            q_mag = mag1 / mag2;
            r_mag = mag1 % mag2;
        end
        // Quotient sign follows the operand signs, remainder follows the dividend.
        q_s     = (Src1[31] ^ Src2[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s     = Src1[31] ? (~r_mag + 32'd1) : r_mag;

        new_hi  = 32'd0;
        new_lo  = 32'd0;
        new_wr  = 1'b1;
        new_cnt = CW'(DIV_CYCLES);
        case (mdOp)
            OP_MULT:  begin new_hi = prod_s[63:32]; new_lo = prod_s[31:0]; new_cnt = CW'(MULT_CYCLES); end
            OP_MULTU: begin new_hi = prod_u[63:32]; new_lo = prod_u[31:0]; new_cnt = CW'(MULT_CYCLES); end
            OP_DIV:   begin new_hi = r_s; new_lo = q_s; new_wr = (Src2 != 32'd0); end
            OP_DIVU:  begin new_hi = r_u; new_lo = q_u; new_wr = (Src2 != 32'd0); end
            default:  new_wr = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: leave IDLE on an accepted start, return when the count expires.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (op_start) state_next = RUN;
            RUN:     if (op_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter, pending result and the HI/LO registers (including MTHI/MTLO when idle).
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_wr <= 1'b0;
            HI     <= 32'd0;
            LO     <= 32'd0;
        end else if (state == IDLE) begin
            if (op_start) begin
                cnt    <= new_cnt;
                res_hi <= new_hi;
                res_lo <= new_lo;
                res_wr <= new_wr;
            end else if (mdOp == OP_MTHI) begin
                HI <= Src1;
            end else if (mdOp == OP_MTLO) begin
                LO <= Src1;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (op_done && res_wr) begin
                HI <= res_hi;
                LO <= res_lo;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_mul_div_unit;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk;
    logic        reset;
    logic [31:0] Src1;
    logic [31:0] Src2;
    logic [2:0]  mdOp;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_total = 0;
    int n_pass  = 0;

    mul_div_unit #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Src1 (Src1),
        .Src2 (Src2),
        .mdOp (mdOp),
        .start(start),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: an accepted op pushes its final {HI,LO} and sets the
    // first idle cycle number; HI/LO take the queued value when that cycle begins.
    logic [63:0] exp_q[$];
    int          cyc      = 0;
    int          end_cyc  = 0;
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;
    logic        checking = 1'b0;

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1:    return 64'(sa * sb);
            3'd2:    return {32'd0, a} * {32'd0, b};
            3'd3:    if (b == 32'd0) return {hi, lo}; else return {32'(sa % sb), 32'(sa / sb)};
            3'd4:    if (b == 32'd0) return {hi, lo}; else return {a % b, a / b};
            default: return {hi, lo};
        endcase
    endfunction

    always @(posedge clk) begin
        logic        was_idle;
        logic [63:0] r;
        was_idle = (cyc >= end_cyc);
        cyc++;
        if (reset) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
            end_cyc = cyc;
            exp_q.delete();
            checking = 1'b1;
        end else if (was_idle) begin
            if (start && mdOp >= 3'd1 && mdOp <= 3'd4) begin
                exp_q.push_back(ref_result(mdOp, Src1, Src2, m_hi, m_lo));
                end_cyc = cyc + ((mdOp <= 3'd2) ? MULT_CYCLES : DIV_CYCLES);
            end else if (mdOp == 3'd5) begin
                m_hi = Src1;
            end else if (mdOp == 3'd6) begin
                m_lo = Src1;
            end
        end else if (cyc == end_cyc) begin
            r = exp_q.pop_front();
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
    end

    // Compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        if (checking) begin
            check("cmp_busy", {31'd0, busy}, {31'd0, (cyc < end_cyc)});
            check("cmp_hi", HI, m_hi);
            check("cmp_lo", LO, m_lo);
        end
    end

    // Drivers: inputs change 1 time unit after the rising edge.
    task automatic drive(input logic rst, input logic [2:0] op, input logic st,
                         input logic [31:0] a, input logic [31:0] b);
        reset = rst;
        mdOp  = op;
        start = st;
        Src1  = a;
        Src2  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, ($urandom_range(0, 1) != 0) ? 3'd0 : 3'd7, 1'($urandom_range(0, 1)),
                  $urandom, $urandom);
    endtask

    task automatic expect_state(input string name, input logic b, input logic [31:0] hi,
                                input logic [31:0] lo);
        check({name, "_busy"}, {31'd0, busy}, {31'd0, b});
        check({name, "_hi"}, HI, hi);
        check({name, "_lo"}, LO, lo);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] hi,
                          input logic [31:0] lo);
        drive(1'b0, op, 1'b1, a, b);
        for (int i = 0; i < n; i++) begin
            check({name, "_busy_run"}, {31'd0, busy}, 32'd1);
            idle(1);
        end
        expect_state({name, "_done"}, 1'b0, hi, lo);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        mdOp  = 3'd0;
        start = 1'b0;
        Src1  = 32'd0;
        Src2  = 32'd0;
        drive(1'b1, 3'd0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 3'd0, 1'b0, 32'd0, 32'd0);
        expect_state("reset", 1'b0, 32'd0, 32'd0);

        run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, MULT_CYCLES, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_CYCLES, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, DIV_CYCLES, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 3'd4, 32'd7, 32'd2, DIV_CYCLES, 32'd1, 32'd3);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_CYCLES, 32'd0, 32'h8000_0000);

        drive(1'b0, 3'd5, 1'b0, 32'h0000_1234, 32'd0);
        drive(1'b0, 3'd6, 1'b0, 32'h0000_5678, 32'd0);
        expect_state("mt_setup", 1'b0, 32'h0000_1234, 32'h0000_5678);
        run_op("divu_zero", 3'd4, 32'hCAFE_F00D, 32'd0, DIV_CYCLES, 32'h0000_1234, 32'h0000_5678);

        // MTHI with start asserted: no busy cycle, HI written next cycle.
        drive(1'b0, 3'd5, 1'b1, 32'hAAAA_0000, 32'd9);
        expect_state("mthi_idle", 1'b0, 32'hAAAA_0000, 32'h0000_5678);

        // MTLO and a second start during a MULT are both dropped.
        drive(1'b0, 3'd1, 1'b1, 32'd3, 32'd4);
        drive(1'b0, 3'd6, 1'b0, 32'h0000_DEAD, 32'd0);
        drive(1'b0, 3'd4, 1'b1, 32'd100, 32'd7);
        expect_state("mid_mult", 1'b1, 32'hAAAA_0000, 32'h0000_5678);
        idle(3);
        expect_state("mult_sched", 1'b0, 32'd0, 32'd12);

        // Reset in the third busy cycle of a DIV aborts it.
        drive(1'b0, 3'd3, 1'b1, 32'd100, 32'd3);
        idle(2);
        drive(1'b1, 3'd0, 1'b0, 32'd0, 32'd0);
        expect_state("abort", 1'b0, 32'd0, 32'd0);
        idle(DIV_CYCLES + 2);
        expect_state("no_late_wb", 1'b0, 32'd0, 32'd0);
        run_op("mult_6x7", 3'd1, 32'd6, 32'd7, MULT_CYCLES, 32'd0, 32'd42);

        // Randomized traffic, checked by the compare process.
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 149) == 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0), pick_operand(),
                  ($urandom_range(0, 9) == 0) ? 32'd0 : pick_operand());
        end
        idle(DIV_CYCLES + 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
